// File: rtl/cpu_launcher.sv
// Sequences NPROG back-to-back CPU program runs: reset pulse, run request,
// bounded run with cycle counting, one-cycle result report per run.
module cpu_launcher #(
  parameter int NPROG   = 3,
  parameter int RST_CYC = 2,
  parameter int TIMEOUT = 1000,
  parameter int CW      = 16,
  localparam int IW     = (NPROG > 1) ? $clog2(NPROG) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          cpu_reset,
  output logic          cpu_req,
  input  logic          cpu_done,
  output logic          busy,
  output logic [IW-1:0] run_idx,
  output logic [CW-1:0] cycles,
  output logic          result_valid,
  output logic          timeout_err,
  output logic          all_done
);

  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC + 1) : 1;
  localparam logic [CW-1:0] TMO      = CW'(TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX = IW'(NPROG - 1);
  localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYC - 1);

  typedef enum logic [2:0] {IDLE, RST, REQ, RUN, REPORT, FINISH} state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] rst_cnt;
  logic [CW-1:0] run_cnt;
  logic [CW-1:0] cnt_inc;
  logic          more_runs;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign cnt_inc   = sat_inc(run_cnt);
  assign more_runs = !timeout_err && (run_idx < LAST_IDX);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FINISH: if (start) state_nxt = RST;
      RST:          if (rst_cnt == '0) state_nxt = REQ;
      REQ:          state_nxt = RUN;
      RUN:          if (cpu_done || cnt_inc >= TMO) state_nxt = REPORT;
      REPORT:       state_nxt = more_runs ? RST : FINISH;
      default:      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_reset    = (state == IDLE) || (state == RST) || (state == FINISH);
    cpu_req      = (state == REQ);
    busy         = (state != IDLE) && (state != FINISH);
    result_valid = (state == REPORT);
    all_done     = (state == FINISH);
  end

  // Run bookkeeping: done on the same cycle as the limit takes priority over timeout
  always_ff @(posedge clk) begin
    if (!reset) begin
      rst_cnt     <= '0;
      run_cnt     <= '0;
      run_idx     <= '0;
      cycles      <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          if (start) begin
            run_idx     <= '0;
            cycles      <= '0;
            timeout_err <= 1'b0;
            rst_cnt     <= RST_LOAD;
          end
        end
        RST: if (rst_cnt != '0) rst_cnt <= rst_cnt - 1'b1;
        REQ: run_cnt <= '0;
        RUN: begin
          run_cnt <= cnt_inc;
          if (cpu_done) begin
            cycles <= cnt_inc;
          end else if (cnt_inc >= TMO) begin
            cycles      <= TMO;
            timeout_err <= 1'b1;
          end
        end
        REPORT: begin
          if (more_runs) begin
            run_idx <= run_idx + 1'b1;
            rst_cnt <= RST_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_launcher.sv
// Scoreboard bench for cpu_launcher: a small core model raises done on a
// per-run schedule, expected reports are queued and checked on result_valid.
module tb_cpu_launcher;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       cpu_reset, cpu_req, busy, result_valid, timeout_err, all_done;
  logic       cpu_done = 1'b0;
  logic [1:0] run_idx;
  logic [15:0] cycles;

  cpu_launcher #(.NPROG(3), .RST_CYC(2), .TIMEOUT(1000), .CW(16)) dut (
    .clk(clk), .reset(reset), .start(start), .cpu_reset(cpu_reset),
    .cpu_req(cpu_req), .cpu_done(cpu_done), .busy(busy), .run_idx(run_idx),
    .cycles(cycles), .result_valid(result_valid), .timeout_err(timeout_err),
    .all_done(all_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int cyc;
    int to;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Core model: done_tbl[k] = RUN cycle of run k on which done rises (0 = never)
  int   done_tbl[3] = '{0, 0, 0};
  bit   pre_high = 1'b0;
  int   rc = 0;
  int   run_no = -1;

  always @(negedge clk) begin
    int dat;
    if (!busy) run_no = -1;
    if (cpu_req) begin
      rc = 0;
      run_no = run_no + 1;
    end else begin
      rc = rc + 1;
    end
    dat = (run_no >= 0 && run_no < 3) ? done_tbl[run_no] : 0;
    cpu_done = (pre_high && busy && (cpu_reset || cpu_req)) ||
               (dat != 0 && rc >= dat && busy && !cpu_reset && !cpu_req);
  end

  // Monitor: every report must match the next queued expectation
  always @(negedge clk) begin
    if (reset && result_valid) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_report: run_idx=%0d cycles=%0d timeout_err=%0d, none expected",
                 run_idx, cycles, timeout_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (int'(run_idx) != e.idx || int'(cycles) != e.cyc || int'(timeout_err) != e.to) begin
          n_fail++;
          $display("FAIL report: got idx=%0d cyc=%0d to=%0d, expected idx=%0d cyc=%0d to=%0d",
                   run_idx, cycles, timeout_err, e.idx, e.cyc, e.to);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input int cyc, input int to);
    exp_t e;
    e.idx = idx; e.cyc = cyc; e.to = to;
    exp_q.push_back(e);
  endtask

  // Leaves the bench at the negedge of cycle 1 (first RST cycle)
  task automatic start_pulse();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_finish(input string name, input int max_cyc);
    int n;
    n = 0;
    while (!all_done && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_finish_reached"}, int'(all_done), 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cpu_reset"}, int'(cpu_reset), 1);
    chk({tag, "_cpu_req"}, int'(cpu_req), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_run_idx"}, int'(run_idx), 0);
    chk({tag, "_cycles"}, int'(cycles), 0);
    chk({tag, "_result_valid"}, int'(result_valid), 0);
    chk({tag, "_timeout_err"}, int'(timeout_err), 0);
    chk({tag, "_all_done"}, int'(all_done), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Three normal runs, done on RUN cycle 5; also check start-to-request latency
    done_tbl = '{5, 5, 5};
    push(0, 5, 0); push(1, 5, 0); push(2, 5, 0);
    start_pulse();
    chk("lat_c1_cpu_reset", int'(cpu_reset), 1);
    chk("lat_c1_busy", int'(busy), 1);
    chk("lat_c1_cpu_req", int'(cpu_req), 0);
    @(negedge clk);
    chk("lat_c2_cpu_reset", int'(cpu_reset), 1);
    chk("lat_c2_cpu_req", int'(cpu_req), 0);
    @(negedge clk);
    chk("lat_c3_cpu_req", int'(cpu_req), 1);
    chk("lat_c3_cpu_reset", int'(cpu_reset), 0);
    wait_finish("normal", 200);
    chk("normal_timeout_err", int'(timeout_err), 0);
    chk("normal_run_idx", int'(run_idx), 2);
    chk("normal_cycles", int'(cycles), 5);
    chk("normal_cpu_reset", int'(cpu_reset), 1);

    // Run 1 never finishes: timeout aborts run 2
    done_tbl = '{5, 0, 0};
    push(0, 5, 0); push(1, 1000, 1);
    start_pulse();
    chk("restart_timeout_clr", int'(timeout_err), 0);
    chk("restart_cycles_clr", int'(cycles), 0);
    chk("restart_run_idx_clr", int'(run_idx), 0);
    wait_finish("timeout", 3000);
    chk("timeout_err_set", int'(timeout_err), 1);
    chk("timeout_run_idx", int'(run_idx), 1);
    chk("timeout_cycles", int'(cycles), 1000);
    repeat (10) @(negedge clk);
    chk("timeout_no_run2", int'(busy), 0);
    chk("timeout_err_sticky", int'(timeout_err), 1);

    // Done exactly on the limit wins over timeout; shortest runs afterwards
    done_tbl = '{1000, 1, 2};
    push(0, 1000, 0); push(1, 1, 0); push(2, 2, 0);
    start_pulse();
    wait_finish("limit", 3000);
    chk("limit_timeout_err", int'(timeout_err), 0);
    chk("limit_run_idx", int'(run_idx), 2);

    // Done high during RST/REQ is ignored; start while busy is ignored
    pre_high = 1'b1;
    done_tbl = '{3, 3, 3};
    push(0, 3, 0); push(1, 3, 0); push(2, 3, 0);
    start_pulse();
    for (int i = 0; i < 4; i++) begin
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      @(negedge clk);
    end
    wait_finish("ignore", 200);
    chk("ignore_cycles", int'(cycles), 3);
    pre_high = 1'b0;

    // Reset asserted on RUN cycle 7 of run 0
    done_tbl = '{0, 0, 0};
    start_pulse();
    n = 0;
    while (!cpu_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_req_seen", int'(cpu_req), 1);
    repeat (7) @(negedge clk);
    chk("abort_in_run", int'(busy), 1);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("abort");
    reset = 1'b1;
    @(negedge clk);

    done_tbl = '{4, 4, 4};
    push(0, 4, 0); push(1, 4, 0); push(2, 4, 0);
    start_pulse();
    wait_finish("after_abort", 200);
    chk("after_abort_run_idx", int'(run_idx), 2);
    chk("after_abort_cycles", int'(cycles), 4);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_launcher.md
CPU_LAUNCHER -- requirements
Module: cpu_launcher

Interface
REQ-001 Parameter NPROG, default 3, SHALL be the number of back-to-back program runs per start.
REQ-002 Parameter RST_CYC, default 2, SHALL be the number of cycles cpu_reset is held high before each run.
REQ-003 Parameter TIMEOUT, default 1000, SHALL be the maximum number of RUN cycles allowed per run.
REQ-004 Parameter CW, default 16, SHALL be the width of the cycle counter.
REQ-005 Port clk, input, 1: SHALL be the single clock.
REQ-006 Port reset, input, 1: SHALL be a synchronous, active-low reset.
REQ-007 Port start, input, 1: SHALL be a start request, sampled in IDLE and FINISH only.
REQ-008 Port cpu_reset, output, 1: SHALL be the reset to the CPU core, active-high.
REQ-009 Port cpu_req, output, 1: SHALL be the run request to the CPU core.
REQ-010 Port cpu_done, input, 1: SHALL be the CPU halt/done level.
REQ-011 Port busy, output, 1: SHALL be high in every state except IDLE and FINISH.
REQ-012 Port run_idx, output, $clog2(NPROG): SHALL be the index of the current or last run.
REQ-013 Port cycles, output, CW: SHALL be the cycle count of the last completed run.
REQ-014 Port result_valid, output, 1: SHALL be a one-cycle pulse marking a valid cycles and run_idx.
REQ-015 Port timeout_err, output, 1: SHALL be a sticky timeout flag.
REQ-016 Port all_done, output, 1: SHALL be high in FINISH.

Function
REQ-017 States SHALL be IDLE, RST, REQ, RUN, REPORT and FINISH, with a registered state.
REQ-018 In IDLE, when start=1, the block SHALL go to RST, clear run_idx, clear timeout_err and clear cycles.
REQ-019 RST SHALL hold cpu_reset=1 for exactly RST_CYC cycles using a down-counter, then go to REQ.
REQ-020 REQ SHALL last one cycle with cpu_req=1 and cpu_reset=0, clear the run counter, then go to RUN.
REQ-021 cpu_req SHALL be 1 only in REQ.
REQ-022 cpu_reset SHALL be 1 in IDLE, RST and FINISH, and 0 in REQ, RUN and REPORT.
REQ-023 RUN SHALL increment the run counter by one every cycle.
REQ-024 cpu_done SHALL be sampled only in RUN; done high in RST, REQ or REPORT SHALL be ignored.
REQ-025 In RUN, on the first cycle with cpu_done=1, cycles SHALL be loaded with the count of RUN cycles including that cycle (done on the first RUN cycle gives cycles=1), and the next state SHALL be REPORT.
REQ-026 In RUN, if the count reaches TIMEOUT with cpu_done=0:
- cycles SHALL be set to TIMEOUT;
- timeout_err SHALL be set to 1;
- the next state SHALL be REPORT.
REQ-027 If cpu_done=1 on the cycle the count reaches TIMEOUT, done SHALL win: no timeout and cycles=TIMEOUT.
REQ-028 The counter SHALL saturate at 2^CW-1 and never wrap; TIMEOUT SHALL be at most 2^CW-1.
REQ-029 REPORT SHALL last one cycle with result_valid=1, driving cycles and run_idx stable.
REQ-030 From REPORT, with timeout_err=0 and run_idx<NPROG-1, the block SHALL increment run_idx and go to RST.
REQ-031 From REPORT otherwise, the block SHALL go to FINISH; a timeout SHALL abort the remaining runs.
REQ-032 FINISH SHALL hold all_done=1, hold cycles, run_idx and timeout_err, and go to RST on start=1, clearing run_idx, timeout_err and cycles.
REQ-033 start in RST, REQ, RUN or REPORT SHALL be ignored.
REQ-034 Latency from start sampled high in IDLE to cpu_req=1 SHALL be RST_CYC+1 cycles.

Reset
REQ-035 With reset=0 at a clock edge, the block SHALL set: state=IDLE, cpu_reset=1, cpu_req=0, busy=0, run_idx=0, cycles=0, result_valid=0, timeout_err=0, all_done=0, counters=0.
REQ-036 Reset asserted mid-run SHALL abort at the next edge with no result_valid pulse.

Verification
REQ-037 NPROG=3, RST_CYC=2; start pulse at cycle 0 -> cpu_reset=1 in cycles 1-2, cpu_req=1 in cycle 3.
REQ-038 Core raises done on the 5th RUN cycle of each run -> three result_valid pulses with run_idx 0, 1, 2 and cycles=5, then all_done=1 and timeout_err=0.
REQ-039 TIMEOUT=1000 with done never raised on run 1 -> result_valid with run_idx=1, cycles=1000, timeout_err=1; FINISH with no run 2.
REQ-040 Done rises on exactly RUN cycle 1000 -> cycles=1000, timeout_err=0, and the next run proceeds.
REQ-041 Done held high during RST/REQ, then low, then high at RUN cycle 3 -> cycles=3; start pulses during busy -> no effect.
REQ-042 reset=0 at RUN cycle 7 of run 0 -> all outputs at reset values next cycle with no result_valid; a new start after release -> normal sequence from run_idx=0.
